// File: rtl/fpu_req_arbiter.sv
// Round-robin arbiter sharing one combinational FPU between two requesters.
// Define FPU_ARB_STATS_EN to add per-requester accept counters (stat_cnt0/stat_cnt1).
module fpu_req_arbiter #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [1:0]      req0_op,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [1:0]      req1_op,
  output logic            req1_ready,
  output logic [XLEN-1:0] fpu_a,
  output logic [XLEN-1:0] fpu_b,
  output logic [1:0]      fpu_op,
  input  logic [XLEN-1:0] fpu_result,
  output logic            resp_valid,
  output logic            resp_id,
  output logic [XLEN-1:0] resp_data,
  input  logic            resp_ready,
  output logic            busy
`ifdef FPU_ARB_STATS_EN
  ,
  output logic [15:0]     stat_cnt0,
  output logic [15:0]     stat_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [XLEN-1:0] fpu_a_q, fpu_a_d;
  logic [XLEN-1:0] fpu_b_q, fpu_b_d;
  logic [1:0]      fpu_op_q, fpu_op_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic            resp_id_q, resp_id_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            grant0, grant1;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && (!req1_valid || last_grant_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    fpu_a_d      = fpu_a_q;
    fpu_b_d      = fpu_b_q;
    fpu_op_d     = fpu_op_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          fpu_a_d      = grant1 ? req1_a  : req0_a;
          fpu_b_d      = grant1 ? req1_b  : req0_b;
          fpu_op_d     = grant1 ? req1_op : req0_op;
          resp_id_d    = grant1;
          last_grant_d = grant1;
          cnt_d        = CNT_INIT;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          resp_data_d = fpu_result;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      fpu_op_q     <= '0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      fpu_a_q      <= fpu_a_d;
      fpu_b_q      <= fpu_b_d;
      fpu_op_q     <= fpu_op_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      cnt_q        <= cnt_d;
    end
  end

  // Ready is masked during reset so nothing looks accepted while rst_n is low.
  assign req0_ready = grant0 & rst_n;
  assign req1_ready = grant1 & rst_n;
  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign fpu_op     = fpu_op_q;
  assign resp_valid = (state_q == RESP);
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != IDLE);

`ifdef FPU_ARB_STATS_EN
  logic [15:0] stat_cnt0_q, stat_cnt0_d;
  logic [15:0] stat_cnt1_q, stat_cnt1_d;

  always_comb begin
    stat_cnt0_d = stat_cnt0_q + {15'd0, grant0};
    stat_cnt1_d = stat_cnt1_q + {15'd0, grant1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt0_q <= '0;
      stat_cnt1_q <= '0;
    end else begin
      stat_cnt0_q <= stat_cnt0_d;
      stat_cnt1_q <= stat_cnt1_d;
    end
  end

  assign stat_cnt0 = stat_cnt0_q;
  assign stat_cnt1 = stat_cnt1_q;
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed self-checking bench for fpu_req_arbiter (LATENCY = 2).
// The FPU is replaced by a bench-driven value or a simple stand-in function.
module tb_fpu_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic        req0_ready, req1_ready;
  logic [31:0] fpu_a, fpu_b, fpu_result;
  logic [1:0]  fpu_op;
  logic        resp_valid, resp_id, resp_ready, busy;
  logic [31:0] resp_data;
`ifdef FPU_ARB_STATS_EN
  logic [15:0] stat_cnt0, stat_cnt1;
`endif

  int          checks = 0;
  int          errors = 0;
  logic        use_model;
  logic [31:0] fpu_result_drv;
  logic [31:0] exp_data;
  logic        exp_id;

  always #5 clk = ~clk;

  function automatic logic [31:0] fpuModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
    return (a + b) ^ {30'd0, op};
  endfunction

  assign fpu_result = use_model ? fpuModel(fpu_a, fpu_b, fpu_op) : fpu_result_drv;

  fpu_req_arbiter #(.XLEN(32), .LATENCY(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .req1_ready (req1_ready),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_op     (fpu_op),
    .fpu_result (fpu_result),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .busy       (busy)
`ifdef FPU_ARB_STATS_EN
    ,
    .stat_cnt0  (stat_cnt0),
    .stat_cnt1  (stat_cnt1)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    #1;
    while (!(req0_ready || req1_ready) && n < 20) begin
      tick();
      #1;
      n++;
    end
    checkOutput("ready_seen", {31'd0, req0_ready | req1_ready}, 32'd1);
  endtask

  task automatic waitResp();
    int n;
    n = 0;
    #1;
    while (!resp_valid && n < 20) begin
      tick();
      #1;
      n++;
    end
    checkOutput("resp_seen", {31'd0, resp_valid}, 32'd1);
  endtask

`ifdef FPU_ARB_STATS_EN
  task automatic applyStimulus(input logic id, input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] op);
    if (id) begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end
    waitReady();
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    waitResp();
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    rst_n          = 1'b0;
    req0_valid     = 1'b1;
    req1_valid     = 1'b1;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    resp_ready     = 1'b0;
    use_model      = 1'b0;
    fpu_result_drv = '0;

    // Reset values, with both requesters pushing during reset.
    #12;
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_busy",       {31'd0, busy},       32'd0);
    checkOutput("rst_ready0",     {31'd0, req0_ready}, 32'd0);
    checkOutput("rst_ready1",     {31'd0, req1_ready}, 32'd0);
    checkOutput("rst_fpu_a",      fpu_a,               32'd0);
    checkOutput("rst_fpu_b",      fpu_b,               32'd0);
    checkOutput("rst_fpu_op",     {30'd0, fpu_op},     32'd0);
    checkOutput("rst_resp_data",  resp_data,           32'd0);
    checkOutput("rst_resp_id",    {31'd0, resp_id},    32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1 rst_n = 1'b1;
    tick();

    // Single request: 2.1 + 2.1 = 4.2, response three cycles after accept.
    resp_ready     = 1'b1;
    fpu_result_drv = 32'h40866666;
    req0_a = 32'h40066666; req0_b = 32'h40066666; req0_op = 2'b00; req0_valid = 1'b1;
    #1;
    checkOutput("single_ready0", {31'd0, req0_ready}, 32'd1);
    checkOutput("single_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    #1;
    checkOutput("single_ready0_off", {31'd0, req0_ready}, 32'd0);
    checkOutput("single_busy",       {31'd0, busy},       32'd1);
    checkOutput("single_rv_t1",      {31'd0, resp_valid}, 32'd0);
    checkOutput("single_fpu_a",      fpu_a,               32'h40066666);
    checkOutput("single_fpu_b",      fpu_b,               32'h40066666);
    checkOutput("single_fpu_op",     {30'd0, fpu_op},     32'd0);
    tick(); #1;
    checkOutput("single_rv_t2",      {31'd0, resp_valid}, 32'd0);
    tick(); #1;
    checkOutput("single_rv_t3",      {31'd0, resp_valid}, 32'd1);
    checkOutput("single_resp_id",    {31'd0, resp_id},    32'd0);
    checkOutput("single_resp_data",  resp_data,           32'h40866666);
    tick(); #1;
    checkOutput("single_idle_busy",  {31'd0, busy},       32'd0);
    checkOutput("single_idle_rv",    {31'd0, resp_valid}, 32'd0);

    // Round-robin with both requesters always valid: grants 0,1,0,1.
    doReset();
    use_model  = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_a = 32'h1000_0000 + 32'(i); req0_b = 32'h0000_0100 * 32'(i + 1); req0_op = 2'(i);
      req1_a = 32'h2000_0000 + 32'(3 * i); req1_b = 32'h0F0F_0000; req1_op = 2'(3 - i);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      waitReady();
      checkOutput("rr_onehot", {31'd0, req0_ready} + {31'd0, req1_ready}, 32'd1);
      checkOutput("rr_grant",  {31'd0, req1_ready}, 32'(i % 2));
      exp_id   = (i % 2 == 1);
      exp_data = exp_id ? fpuModel(req1_a, req1_b, req1_op) : fpuModel(req0_a, req0_b, req0_op);
      tick();
      waitResp();
      checkOutput("rr_resp_id",   {31'd0, resp_id}, {31'd0, exp_id});
      checkOutput("rr_resp_data", resp_data,        exp_data);
      tick();
    end

    // Backpressure: response held for ten cycles, pending requesters stalled.
    resp_ready = 1'b0;
    req0_a = 32'hA5A5_0001; req0_b = 32'h0000_0003; req0_op = 2'b10;
    req1_a = 32'h5A5A_0002; req1_b = 32'h0000_0004; req1_op = 2'b01;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    waitReady();
    checkOutput("bp_grant0", {31'd0, req0_ready}, 32'd1);
    exp_data = 32'hA5A5_0004 ^ 32'd2;
    tick();
    waitResp();
    for (int k = 0; k < 10; k++) begin
      checkOutput("bp_rv",     {31'd0, resp_valid}, 32'd1);
      checkOutput("bp_data",   resp_data,           exp_data);
      checkOutput("bp_id",     {31'd0, resp_id},    32'd0);
      checkOutput("bp_ready0", {31'd0, req0_ready}, 32'd0);
      checkOutput("bp_ready1", {31'd0, req1_ready}, 32'd0);
      tick(); #1;
    end
    resp_ready = 1'b1;
    tick(); #1;
    checkOutput("bp_rearb_ready1", {31'd0, req1_ready}, 32'd1);
    checkOutput("bp_rearb_ready0", {31'd0, req0_ready}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Operand hold: requester inputs and FPU result move during EXEC.
    use_model      = 1'b0;
    fpu_result_drv = 32'hDEADBEEF;
    req1_a = 32'hC1719999; req1_b = 32'h40133333; req1_op = 2'b11; req1_valid = 1'b1;
    #1;
    checkOutput("hold_ready1", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_a = 32'h12345678; req1_b = 32'h9ABCDEF0; req1_op = 2'b00;
    fpu_result_drv = 32'h11111111;
    #1;
    checkOutput("hold_fpu_a_e1",  fpu_a,               32'hC1719999);
    checkOutput("hold_fpu_b_e1",  fpu_b,               32'h40133333);
    checkOutput("hold_fpu_op_e1", {30'd0, fpu_op},     32'd3);
    checkOutput("hold_ready1_e1", {31'd0, req1_ready}, 32'd0);
    tick();
    fpu_result_drv = 32'hC0D21625;
    #1;
    checkOutput("hold_fpu_a_e2",  fpu_a,               32'hC1719999);
    checkOutput("hold_fpu_b_e2",  fpu_b,               32'h40133333);
    checkOutput("hold_fpu_op_e2", {30'd0, fpu_op},     32'd3);
    checkOutput("hold_rv_e2",     {31'd0, resp_valid}, 32'd0);
    tick();
    fpu_result_drv = 32'h22222222;
    #1;
    checkOutput("hold_rv",        {31'd0, resp_valid}, 32'd1);
    checkOutput("hold_resp_data", resp_data,           32'hC0D21625);
    checkOutput("hold_resp_id",   {31'd0, resp_id},    32'd1);
    checkOutput("hold_ready1_r",  {31'd0, req1_ready}, 32'd0);
    req1_valid = 1'b0;
    tick(); #1;
    checkOutput("hold_idle_busy", {31'd0, busy},       32'd0);

    // Asynchronous reset in the middle of EXEC.
    use_model = 1'b1;
    req0_a = 32'h0000_0077; req0_b = 32'h0000_0011; req0_op = 2'b01; req0_valid = 1'b1;
    #1;
    checkOutput("mid_ready0", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_busy",   {31'd0, busy},       32'd0);
    checkOutput("mid_rv",     {31'd0, resp_valid}, 32'd0);
    checkOutput("mid_fpu_a",  fpu_a,               32'd0);
    checkOutput("mid_ready0_rst", {31'd0, req0_ready}, 32'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checkOutput("mid_tie_in_rst0", {31'd0, req0_ready}, 32'd0);
    checkOutput("mid_tie_in_rst1", {31'd0, req1_ready}, 32'd0);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("mid_tie_ready0", {31'd0, req0_ready}, 32'd1);
    checkOutput("mid_tie_ready1", {31'd0, req1_ready}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

`ifdef FPU_ARB_STATS_EN
    // Accept counters per requester.
    doReset();
    checkOutput("stat0_rst", {16'd0, stat_cnt0}, 32'd0);
    checkOutput("stat1_rst", {16'd0, stat_cnt1}, 32'd0);
    applyStimulus(1'b0, 32'd1, 32'd2, 2'b00);
    applyStimulus(1'b1, 32'd3, 32'd4, 2'b01);
    applyStimulus(1'b0, 32'd5, 32'd6, 2'b10);
    applyStimulus(1'b1, 32'd7, 32'd8, 2'b11);
    applyStimulus(1'b0, 32'd9, 32'd10, 2'b00);
    checkOutput("stat0_cnt", {16'd0, stat_cnt0}, 32'd3);
    checkOutput("stat1_cnt", {16'd0, stat_cnt1}, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_req_arbiter.md
Name: fpu_req_arbiter

Overview:
- Shares one combinational FPU (32-bit operands A/B, 2-bit op: 00 add, 01 sub, 10 mul, 11 div, 32-bit result) between two requesters.
- Uses round-robin arbitration and valid/ready handshakes on each request and on the response.
- Holds the FPU operands stable for a programmable settle time, registers the result, and returns it tagged with the requester ID.
- Sits between the issuing units and the FPU instance.

Parameters:
- XLEN, 32, operand and result width.
- LATENCY, 2, number of cycles the FPU inputs are held before the result is sampled; legal range 1..15.

Ports:
- clk  in  1  clock; all flops rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_a  in  XLEN  operand A from requester 0.
- req0_b  in  XLEN  operand B from requester 0.
- req0_op  in  2  operation code from requester 0.
- req0_ready  out  1  requester 0 accepted this cycle.
- req1_valid, req1_a, req1_b, req1_op, req1_ready  same as requester 0, for requester 1.
- fpu_a  out  XLEN  operand A driven to the FPU.
- fpu_b  out  XLEN  operand B driven to the FPU.
- fpu_op  out  2  op code driven to the FPU.
- fpu_result  in  XLEN  FPU result.
- resp_valid  out  1  response available.
- resp_id  out  1  requester ID the response belongs to.
- resp_data  out  XLEN  registered result.
- resp_ready  in  1  consumer accepts the response.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset values: state IDLE; last_grant = 1, so requester 0 wins the first tie. fpu_a, fpu_b, fpu_op, resp_data, cnt and resp_id are all 0. resp_valid = 0, busy = 0, both ready signals 0.
- IDLE:
  - Only one requester valid: grant it.
  - Both valid: grant the one that is not last_grant.
  - The granted reqN_ready = 1 combinationally in that cycle. At most one ready is ever high, and only while in IDLE.
  - On the accept edge: latch that requester's a, b and op into fpu_a, fpu_b and fpu_op; latch its ID; update last_grant; load cnt = LATENCY-1; go to EXEC.
  - Neither valid: stay in IDLE; fpu_* keep their last values.
- EXEC:
  - fpu_* are held constant.
  - cnt != 0: decrement.
  - cnt == 0: capture fpu_result into resp_data, then go to RESP.
- RESP:
  - resp_valid = 1; resp_id and resp_data stay stable until the handshake.
  - resp_valid & resp_ready: go to IDLE.
  - No new accept happens in the same cycle as the response handshake.
- Timing: accept edge at cycle T, resp_valid rises at T+LATENCY+1. Minimum issue-to-issue interval is LATENCY+2 cycles.
- Requester-side rules:
  - Input values are ignored unless reqN_ready is high.
  - A requester may drop valid before being granted without any effect.
  - Inputs that change while not ready are never latched.
- Response backpressure: resp_ready held low keeps RESP indefinitely. Pending requesters stay un-readied.
- Reset mid-operation (EXEC or RESP): everything returns to reset values immediately and the in-flight result is discarded.
- Arithmetic exceptions (NaN, inf, divide by zero) are passed through unchanged; the arbiter never inspects data.

Optional Feature:
- Macro: FPU_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_cnt0 [15:0] and stat_cnt1 [15:0].
  - Each counts accepted requests per requester and increments on that requester's accept edge.
  - Counters wrap from 16'hFFFF to 0.
  - Counters are cleared by rst_n.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Single request: req0 valid, a=0x40066666 (2.1), b=0x40066666, op=00, LATENCY=2 → req0_ready high for one cycle. resp_valid rises 3 cycles after accept with resp_id=0 and resp_data=0x40866666 (4.2).
- Tie and round-robin: both valid every cycle, resp_ready tied high → grants alternate 0,1,0,1. The first grant goes to 0. Exactly one ready per accept.
- Backpressure: hold resp_ready low 10 cycles after resp_valid → resp_data and resp_id are stable throughout. Neither reqN_ready asserts until the handshake, after which IDLE re-arbitrates.
- Operand hold: during EXEC, change req1 inputs and pulse the fpu_result stimulus at an earlier cycle → fpu_a, fpu_b and fpu_op stay constant. resp_data equals fpu_result at the sample cycle only. Check with op=11, a=0xC1719999 (-15.1), b=0x40133333 (2.3).
- Reset mid-EXEC: assert rst_n=0 asynchronously between edges → resp_valid, busy and the ready signals go 0 immediately. After release, the first tie grants requester 0.
- With FPU_ARB_STATS_EN: run 3 accepts from req0 and 2 from req1 → stat_cnt0=3, stat_cnt1=2. Preload-free wrap test at 65536 accepts gives 0.
